// File: rtl/segway_pkg.sv
// Shared Segway definitions: rider-weight thresholds and the steer-enable FSM state type.
package segway_pkg;
  localparam int MIN_RIDER_WT  = 512;
  localparam int WT_HYSTERESIS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;
endpackage

// File: rtl/steer_en_tmr.sv
// Balance qualification timer: 26-bit up-counter with a fast_sim-selectable terminal count.
module steer_en_tmr
  import segway_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic fast_sim,
  output logic tmr_full
);

  localparam int TMR_W  = 26;
  localparam int FAST_W = 14;

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tmr_full = fast_sim ? (&cnt[FAST_W-1:0]) : (&cnt);

endmodule

// File: rtl/steer_en.sv
// Rider-presence / steering-enable controller. Define STEER_EN_HYSTERESIS_EN to use a
// 448 off threshold (64 below the 512 on threshold); otherwise off is sum <= 512.
module steer_en
  import segway_pkg::*;
#(
  parameter bit fast_sim = 1'b1,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_ld,
  input  logic [DATA_W-1:0] rght_ld,
  output logic              en_steer,
  output logic              rider_off
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic [SUM_W-1:0] ON_THRESH  = SUM_W'(MIN_RIDER_WT);
  localparam logic [SUM_W-1:0] OFF_THRESH = SUM_W'(MIN_RIDER_WT - WT_HYSTERESIS);

  function automatic logic [DATA_W-1:0] abs_diff(input logic signed [DATA_W:0] d);
    return (d < 0) ? DATA_W'(-d) : DATA_W'(d);
  endfunction

  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         diff_ext;
  logic signed [DATA_W:0]   delta;
  logic                     sum_gt_min, sum_lt_min;
  logic                     diff_gt_1_4, diff_gt_15_16;
  logic                     tmr_full, tmr_clr, tmr_en;
  steer_state_t             state, nxt;

  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign delta    = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
  assign diff_ext = {1'b0, abs_diff(delta)};

  assign sum_gt_min = sum > ON_THRESH;
`ifdef STEER_EN_HYSTERESIS_EN
  assign sum_lt_min = sum < OFF_THRESH;
`else
  assign sum_lt_min = sum <= ON_THRESH;
`endif

  assign diff_gt_1_4   = diff_ext > (sum >> 2);
  assign diff_gt_15_16 = diff_ext > (sum - (sum >> 4));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Falling below the off threshold wins over any imbalance condition.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (sum_gt_min) nxt = WAIT;
      WAIT: begin
        if (sum_lt_min)        nxt = IDLE;
        else if (diff_gt_1_4)  nxt = WAIT;
        else if (tmr_full)     nxt = STEER;
      end
      STEER: begin
        if (sum_lt_min)          nxt = IDLE;
        else if (diff_gt_15_16)  nxt = WAIT;
      end
      default: nxt = IDLE;
    endcase
  end

  // Timer restarts on every state entry and on any imbalance seen while waiting.
  assign tmr_clr = (nxt != state) || ((state == WAIT) && diff_gt_1_4);
  assign tmr_en  = (state == WAIT);

  steer_en_tmr u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .fast_sim (fast_sim),
    .tmr_full (tmr_full)
  );

  assign rider_off = (state == IDLE);
  assign en_steer  = (state == STEER);

endmodule

// File: tb/tb_steer_en.sv
// Scoreboard bench for steer_en (fast_sim=1): stimulus queues expected outputs, monitor compares.
module tb_steer_en;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_ld, rght_ld;
  logic        en_steer, rider_off;

  typedef struct {
    logic  ro;
    logic  es;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef STEER_EN_HYSTERESIS_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  steer_en #(.fast_sim(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rider_off !== e.ro || en_steer !== e.es) begin
        errors++;
        $display("FAIL %s: got rider_off=%b en_steer=%b, expected rider_off=%b en_steer=%b",
                 e.tag, rider_off, en_steer, e.ro, e.es);
      end
    end
  end

  task automatic expect_out(input string tag, input logic ro, input logic es);
    exp_t e;
    e.ro = ro; e.es = es; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive(input int l, input int r);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0);
    step(2);
    rst = 1'b0;
    expect_out("reset", 1'b1, 1'b0);
    step(20);             expect_out("idle_zero", 1'b1, 1'b0);
    drive(200, 150); step(3);  expect_out("light_load", 1'b1, 1'b0);
    drive(310, 310); step(2);  expect_out("rider_on", 1'b0, 1'b0);
    drive(224, 224); step(2);  expect_out("band_448_wait", !HYST, 1'b0);
    drive(0, 0);     step(1);  expect_out("off_to_idle", 1'b1, 1'b0);
    drive(256, 256); step(2);  expect_out("sum_512_idle", 1'b1, 1'b0);

    // Qualification from IDLE: STEER on the 16385th edge.
    drive(320, 315); step(16384); expect_out("qual_early", 1'b0, 1'b0);
    step(1);                      expect_out("qual_done", 1'b0, 1'b1);

    drive(600, 400); step(2);  expect_out("steer_mild_imbal", 1'b0, 1'b1);
    drive(700, 20);  step(1);  expect_out("steer_tilt", 1'b0, 1'b0);
    drive(330, 330); step(16383); expect_out("requal_early", 1'b0, 1'b0);
    step(1);                      expect_out("requal_done", 1'b0, 1'b1);

    drive(240, 240); step(2);
    if (HYST) expect_out("hyst_steer_480", 1'b0, 1'b1);
    else      expect_out("hyst_steer_480", 1'b1, 1'b0);
    drive(300, 30);  step(2);  expect_out("fall_off_330", 1'b1, 1'b0);
    drive(240, 240); step(2);  expect_out("hyst_idle_480", 1'b1, 1'b0);

    drive(257, 256); step(1);   expect_out("sum_513_on", 1'b0, 1'b0);
    step(999);                  expect_out("wait_hold", 1'b0, 1'b0);
    drive(600, 100); step(3);   expect_out("burst", 1'b0, 1'b0);
    drive(320, 315); step(16383); expect_out("burst_early", 1'b0, 1'b0);
    step(1);                      expect_out("burst_done", 1'b0, 1'b1);

    drive(0, 0);     step(1);   expect_out("rider_drop", 1'b1, 1'b0);

    drive(320, 315); step(16385); expect_out("steer_again", 1'b0, 1'b1);
    rst = 1'b1;      step(1);     expect_out("rst_in_steer", 1'b1, 1'b0);
    rst = 1'b0;      step(1);     expect_out("post_rst_wait", 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
